// File: rtl/mio_bus_if.sv
// CPU-side memory/IO bus: request qualifiers, address/data and the completion pulse.
// Handshake: a request is MemRead|MemWrite with CPU_MIO=1, held until MIO_ready=1 (one-cycle pulse).
interface mio_bus_if;
    logic        CPU_MIO;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] Data_in;
    logic [31:0] Data_out;
    logic        MIO_ready;

    modport master (
        output CPU_MIO, MemRead, MemWrite, addr, Data_in,
        input  Data_out, MIO_ready
    );

    modport slave (
        input  CPU_MIO, MemRead, MemWrite, addr, Data_in,
        output Data_out, MIO_ready
    );
endinterface

// File: rtl/mio_bus.sv
// Memory/IO responder: decodes CPU accesses to a wait-stated sync RAM, an LED/switch port
// and a reloading down-counter timer with a maskable interrupt.
module mio_bus #(
    parameter int RAM_WAIT = 1,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    mio_bus_if.slave          bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [7:0]        led,
    input  logic [7:0]        sw,
    output logic              Ireq,
    input  logic              Iack,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    localparam logic [2:0]  WAIT_LAST = 3'(RAM_WAIT);
    localparam logic [29:0] A_LED     = 30'h3FFF_FF80;
    localparam logic [29:0] A_SW      = 30'h3FFF_FF81;
    localparam logic [29:0] A_TLOAD   = 30'h3FFF_FF82;
    localparam logic [29:0] A_TCTRL   = 30'h3FFF_FF83;
    localparam logic [29:0] A_TCOUNT  = 30'h3FFF_FF84;

    state_t      state, state_nx;
    logic [29:0] req_addr;
    logic [31:0] req_data;
    logic        req_wr;
    logic [2:0]  wait_cnt;
    logic [31:0] tload, tcount;
    logic        en, ie, pend;
    logic        req, ram_in, ram_sel;
    logic [31:0] rd_data;
    logic        wr_commit, tload_wr, tctrl_wr, expire;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, bus.addr[1:0]};
    assign req     = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
    assign ram_in  = (bus.addr[31:12] == 20'd0);
    assign ram_sel = (req_addr[29:10] == 20'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req) state_nx = ram_in ? S_WAIT : S_RESP;
            S_WAIT: if (wait_cnt == WAIT_LAST) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ram_we        = (state == S_WAIT) && req_wr && (wait_cnt == 3'd0);
        bus.MIO_ready = (state == S_RESP);
        bus.Data_out  = ((state == S_RESP) && !req_wr) ? rd_data : 32'd0;
        state_dbg     = state;
    end

    // Request capture; direction resolves to read when both strobes are high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr <= 30'd0;
            req_data <= 32'd0;
            req_wr   <= 1'b0;
            wait_cnt <= 3'd0;
        end else if (state == S_IDLE && req) begin
            req_addr <= bus.addr[31:2];
            req_data <= bus.Data_in;
            req_wr   <= bus.MemWrite & ~bus.MemRead;
            wait_cnt <= 3'd0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    assign ram_addr = req_addr[RAM_AW-1:0];
    assign ram_din  = req_data;

    always_comb begin
        rd_data = 32'd0;
        if (ram_sel) rd_data = ram_dout;
        else begin
            case (req_addr)
                A_LED:    rd_data = {24'd0, led};
                A_SW:     rd_data = {24'd0, sw};
                A_TLOAD:  rd_data = tload;
                A_TCTRL:  rd_data = {29'd0, pend, ie, en};
                A_TCOUNT: rd_data = tcount;
                default:  rd_data = 32'd0;
            endcase
        end
    end

    assign wr_commit = (state == S_RESP) && req_wr && !ram_sel;
    assign tload_wr  = wr_commit && (req_addr == A_TLOAD);
    assign tctrl_wr  = wr_commit && (req_addr == A_TCTRL);
    assign expire    = en && (tcount == 32'd1) && !tload_wr;
    assign Ireq      = pend & ie;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) led <= 8'd0;
        else if (wr_commit && req_addr == A_LED) led <= req_data[7:0];
    end

    // Counter reaches 0 on expiry and reloads on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tload  <= 32'd0;
            tcount <= 32'd0;
            en     <= 1'b0;
            ie     <= 1'b0;
            pend   <= 1'b0;
        end else begin
            if (tload_wr) begin
                tload  <= req_data;
                tcount <= req_data;
            end else if (en) begin
                if (tcount != 32'd0)     tcount <= tcount - 32'd1;
                else if (tload != 32'd0) tcount <= tload;
            end
            if (tctrl_wr) begin
                en <= req_data[0];
                ie <= req_data[1];
            end
            if (expire)                              pend <= 1'b1;
            else if (Iack || (tctrl_wr && req_data[2])) pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mio_bus.sv
// Directed bench for mio_bus: drivers push expected read data and completion cycle,
// a negedge monitor pops and compares on every MIO_ready pulse.
module tb_mio_bus;
    localparam int RAM_WAIT = 1;
    localparam int RAM_AW   = 10;
    localparam int LAT_RAM  = RAM_WAIT + 2;
    localparam int LAT_IO   = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic [7:0]        led;
    logic [7:0]        sw = 8'h00;
    logic              Ireq;
    logic              Iack = 1'b0;
    logic [1:0]        state_dbg;

    mio_bus_if bus_if ();

    mio_bus #(.RAM_WAIT(RAM_WAIT), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .reset(reset), .bus(bus_if),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .led(led), .sw(sw), .Ireq(Ireq), .Iack(Iack), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / RAM model ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:(1<<RAM_AW)-1];
    initial for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'd0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    bit          chk_q[$];
    int          due_q[$];
    string       name_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int ready_cnt = 0;
    int we_cnt    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus_if.MIO_ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL stray_ready: MIO_ready at cycle %0d with no request outstanding", cyc);
            end else begin
                automatic logic [31:0] e  = exp_q.pop_front();
                automatic bit          c  = chk_q.pop_front();
                automatic int          d  = due_q.pop_front();
                automatic string       nm = name_q.pop_front();
                chk({nm, "_latency"}, 32'(cyc), 32'(d));
                if (c) chk({nm, "_data"}, bus_if.Data_out, e);
            end
        end
        if (reset && ram_we) we_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic bus_idle();
        bus_if.CPU_MIO  = 1'b0;
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
        bus_if.addr     = 32'd0;
        bus_if.Data_in  = 32'd0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends RESP.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit chk_data, input logic [31:0] exp, input int lat,
                          input bit drop, input string nm);
        bit got = 1'b0;
        bus_if.CPU_MIO  = 1'b1;
        bus_if.MemRead  = rd;
        bus_if.MemWrite = wr;
        bus_if.addr     = a;
        bus_if.Data_in  = d;
        exp_q.push_back(exp);
        chk_q.push_back(chk_data);
        due_q.push_back(cyc + lat);
        name_q.push_back(nm);
        if (drop) begin
            @(posedge clk); #1;
            bus_idle();
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus_if.MIO_ready) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: no MIO_ready within 20 cycles, required 1 pulse", nm);
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int lat, input string nm);
        access(1'b1, 1'b0, a, 32'd0, 1'b1, exp, lat, 1'b0, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lat, input string nm);
        access(1'b0, 1'b1, a, d, 1'b0, 32'd0, lat, 1'b0, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int rc;
    initial begin
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus_if.MIO_ready), 32'd0);
        chk("rst_data", bus_if.Data_out, 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_ireq", 32'(Ireq), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // RAM, including last word and first address past the RAM window
        wr(32'h0000_0010, 32'hDEAD_BEEF, LAT_RAM, "ram_wr10");
        rd(32'h0000_0010, 32'hDEAD_BEEF, LAT_RAM, "ram_rd10");
        wr(32'h0000_0FFC, 32'h1234_5678, LAT_RAM, "ram_wrffc");
        rd(32'h0000_0FFC, 32'h1234_5678, LAT_RAM, "ram_rdffc");
        rd(32'h0000_1000, 32'd0, LAT_IO, "rd_1000");
        chk("ram_we_pulses", 32'(we_cnt), 32'd2);

        // LED / switches
        wr(32'hFFFF_FE00, 32'h0000_00A5, LAT_IO, "led_wr");
        chk("led_val", 32'(led), 32'hA5);
        rd(32'hFFFF_FE00, 32'hA5, LAT_IO, "led_rd");
        sw = 8'h3C;
        rd(32'hFFFF_FE04, 32'h3C, LAT_IO, "sw_rd");
        access(1'b1, 1'b1, 32'hFFFF_FE00, 32'hFF, 1'b1, 32'hA5, LAT_IO, 1'b0, "both_rd");
        chk("led_after_both", 32'(led), 32'hA5);

        // unmapped and address LSBs
        rd(32'h8000_0000, 32'd0, LAT_IO, "unmap_rd");
        wr(32'h8000_0000, 32'hFF, LAT_IO, "unmap_wr");
        chk("led_after_unmap", 32'(led), 32'hA5);
        rd(32'hFFFF_FE03, 32'hA5, LAT_IO, "led_rd_lsb");

        // back-to-back requests
        rc = ready_cnt;
        rd(32'hFFFF_FE04, 32'h3C, LAT_IO, "b2b_sw");
        rd(32'hFFFF_FE00, 32'hA5, LAT_IO, "b2b_led");
        rd(32'h0000_0010, 32'hDEAD_BEEF, LAT_RAM, "b2b_ram");
        chk("b2b_ready_cnt", 32'(ready_cnt - rc), 32'd3);

        // no CPU_MIO -> no response
        rc = ready_cnt;
        bus_if.MemRead = 1'b1;
        bus_if.addr    = 32'hFFFF_FE00;
        repeat (6) @(posedge clk);
        #1 bus_idle();
        @(posedge clk); #1;
        chk("nomio_ready_cnt", 32'(ready_cnt - rc), 32'd0);

        // request dropped mid-access still completes and commits
        access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'd0, LAT_RAM, 1'b1, "drop_wr");
        rd(32'h0000_0020, 32'hCAFE_F00D, LAT_RAM, "drop_rd");

        // timer: zero reload never expires
        wr(32'hFFFF_FE0C, 32'h3, LAT_IO, "tctrl_wr3");
        repeat (10) @(posedge clk);
        #1 chk("tload0_ireq", 32'(Ireq), 32'd0);
        rd(32'hFFFF_FE10, 32'd0, LAT_IO, "tload0_tcount");
        rd(32'hFFFF_FE0C, 32'h3, LAT_IO, "tctrl_rd3");

        // timer: load 5 -> expiry five edges later, reload, Iack
        wr(32'hFFFF_FE08, 32'd5, LAT_IO, "tload_wr5");
        repeat (4) @(posedge clk);
        #1 chk("t_ireq_before", 32'(Ireq), 32'd0);
        @(posedge clk);
        #1 chk("t_ireq_expire", 32'(Ireq), 32'd1);
        rd(32'hFFFF_FE10, 32'd5, LAT_IO, "t_reload");
        Iack = 1'b1;
        @(posedge clk);
        #1 Iack = 1'b0;
        chk("t_ireq_iack", 32'(Ireq), 32'd0);
        repeat (2) @(posedge clk);
        #1 Iack = 1'b1;
        @(posedge clk);
        #1 Iack = 1'b0;
        chk("t_set_wins", 32'(Ireq), 32'd1);
        wr(32'hFFFF_FE0C, 32'h7, LAT_IO, "tctrl_wr7");
        chk("t_ireq_clr", 32'(Ireq), 32'd0);
        rd(32'hFFFF_FE0C, 32'h3, LAT_IO, "tctrl_rd_clr");

        // reset during first RAM WAIT cycle of a write
        rc = ready_cnt;
        bus_if.CPU_MIO  = 1'b1;
        bus_if.MemWrite = 1'b1;
        bus_if.addr     = 32'h0000_0030;
        bus_if.Data_in  = 32'h55AA_55AA;
        @(posedge clk);
        @(negedge clk);
        chk("abort_we_before", 32'(ram_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_ready", 32'(bus_if.MIO_ready), 32'd0);
        chk("abort_data", bus_if.Data_out, 32'd0);
        chk("abort_led", 32'(led), 32'd0);
        chk("abort_ireq", 32'(Ireq), 32'd0);
        chk("abort_state", 32'(state_dbg), 32'd0);
        bus_idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_ready", 32'(ready_cnt - rc), 32'd0);
        rd(32'h0000_0030, 32'd0, LAT_RAM, "abort_ram");
        rd(32'hFFFF_FE0C, 32'd0, LAT_IO, "abort_tctrl");
        rd(32'hFFFF_FE08, 32'd0, LAT_IO, "abort_tload");
        rd(32'hFFFF_FE10, 32'd0, LAT_IO, "abort_tcount");

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
